// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I definitions: ALU opcodes, operand width, multi-cycle FSM states,
// opcode constants and the datapath mux selects used by control and datapath.
package rv32i_defs;
  localparam int OperandSize = 32;
  localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSltu, AluSll, AluSrl, AluSra
  } alu_opcode_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JAL, S_BRANCH, S_TRAP
  } mc_state_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {ImmI, ImmS, ImmB, ImmJ} imm_src_t;
  typedef enum logic [1:0] {SrcAPc, SrcAOldPc, SrcAReg} src_a_t;
  typedef enum logic [1:0] {SrcBReg, SrcBImm, SrcBFour} src_b_t;
  typedef enum logic [1:0] {PcAlu, PcAluOut, PcOldPc} pc_src_t;
  typedef enum logic [1:0] {ResAluOut, ResData, ResPc} result_t;

  // alt selects sub/sra; callers decide when funct7[5] is meaningful
  function automatic alu_opcode_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction
endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU with zero flag for branch compare.
module alu import rv32i_defs::*; (
  input  logic [OperandSize-1:0] a,
  input  logic [OperandSize-1:0] b,
  input  alu_opcode_t            alu_ctrl,
  output logic [OperandSize-1:0] y,
  output logic                   zero
);
  always_comb begin
    y = '0;
    case (alu_ctrl)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluXor:  y = a ^ b;
      AluSlt:  y = {{(OperandSize-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu: y = {{(OperandSize-1){1'b0}}, a < b};
      AluSll:  y = a << b[4:0];
      AluSrl:  y = a >> b[4:0];
      AluSra:  y = $signed(a) >>> b[4:0];
      default: y = '0;
    endcase
  end
  assign zero = (y == '0);
endmodule

// File: rtl/imm_extend.sv
// Sign-extended immediate generation for I/S/B/J formats.
module imm_extend import rv32i_defs::*; (
  input  logic [31:7]            instr,
  input  imm_src_t               imm_src,
  output logic [OperandSize-1:0] imm
);
  always_comb begin
    imm = '0;
    case (imm_src)
      ImmI: imm = {{20{instr[31]}}, instr[31:20]};
      ImmS: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM with main and ALU decoders; drives every datapath
// enable and mux select. TRAP is terminal until reset.
module multi_cycle_control import rv32i_defs::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ab_write,
  output logic        alu_out_write,
  output logic        data_write,
  output src_a_t      src_a_sel,
  output src_b_t      src_b_sel,
  output pc_src_t     pc_src,
  output result_t     result_sel,
  output imm_src_t    imm_src,
  output alu_opcode_t alu_ctrl,
  output logic        retire,
  output logic        halted
);
  mc_state_t state, next;

  always_ff @(posedge clk)
    if (rst) state <= S_FETCH;
    else     state <= next;

  always_comb begin
    next = state;
    pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    adr_src = 1'b0; ab_write = 1'b0; alu_out_write = 1'b0; data_write = 1'b0;
    src_a_sel = SrcAReg; src_b_sel = SrcBImm; pc_src = PcAluOut; result_sel = ResAluOut;
    imm_src = ImmI; alu_ctrl = AluAdd; retire = 1'b0;
    halted = (state == S_TRAP);
    case (state)
      S_FETCH: begin
        mem_req = 1'b1; src_a_sel = SrcAPc; src_b_sel = SrcBFour; pc_src = PcAlu;
        if (mem_ready) begin ir_write = 1'b1; pc_write = 1'b1; next = S_DECODE; end
      end
      S_DECODE: begin
        // speculative branch/jal target computed while the registers are read
        ab_write = 1'b1; alu_out_write = 1'b1; src_a_sel = SrcAOldPc;
        imm_src = (opcode == OpJal) ? ImmJ : ImmB;
        case (opcode)
          OpLoad, OpStore: next = S_MEM_ADR;
          OpOp:            next = S_EXEC_R;
          OpOpImm:         next = S_EXEC_I;
          OpJal:           next = S_JAL;
          OpBranch:        next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          default:         next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_out_write = 1'b1;
        imm_src = (opcode == OpStore) ? ImmS : ImmI;
        next = (opcode == OpStore) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1; adr_src = 1'b1;
        if (mem_ready) begin data_write = 1'b1; next = S_MEM_WB; end
      end
      S_MEM_WB: begin reg_write = 1'b1; result_sel = ResData; retire = 1'b1; next = S_FETCH; end
      S_MEM_WRITE: begin
        mem_req = 1'b1; mem_we = 1'b1; adr_src = 1'b1;
        if (mem_ready) begin retire = 1'b1; next = S_FETCH; end
      end
      S_EXEC_R: begin
        src_b_sel = SrcBReg; alu_ctrl = alu_decode(funct3, funct7b5);
        alu_out_write = 1'b1; next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_ctrl = alu_decode(funct3, funct7b5 && funct3 == 3'b101);
        alu_out_write = 1'b1; next = S_ALU_WB;
      end
      S_ALU_WB: begin reg_write = 1'b1; retire = 1'b1; next = S_FETCH; end
      S_JAL: begin
        reg_write = 1'b1; result_sel = ResPc; pc_write = 1'b1; retire = 1'b1; next = S_FETCH;
      end
      S_BRANCH: begin
        src_b_sel = SrcBReg; alu_ctrl = AluSub;
        pc_write = funct3[0] ? !zero : zero; retire = 1'b1; next = S_FETCH;
      end
      S_TRAP: begin pc_write = 1'b1; pc_src = PcOldPc; end
      default: next = S_FETCH;
    endcase
    // nothing leaves the core during reset, even mid-transaction
    if (rst) begin mem_req = 1'b0; mem_we = 1'b0; reg_write = 1'b0; end
  end
endmodule

// File: rtl/register_file.sv
// 32 x 32 register file, two async reads, one sync write; x0 hardwired to zero.
module register_file import rv32i_defs::*; (
  input  logic                   clk,
  input  logic                   we,
  input  logic [4:0]             ra1,
  input  logic [4:0]             ra2,
  input  logic [4:0]             wa,
  input  logic [OperandSize-1:0] wd,
  output logic [OperandSize-1:0] rd1,
  output logic [OperandSize-1:0] rd2
);
  logic [OperandSize-1:0] regs [32];

  always_ff @(posedge clk)
    if (we && wa != 5'd0) regs[wa] <= wd;

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/multi_cycle_datapath.sv
// RV32I multi-cycle core datapath: shared memory port, one ALU reused across
// states, instruction-retire counter and sticky halt on illegal opcodes.
module multi_cycle_datapath import rv32i_defs::*; #(
  parameter logic [31:0] ResetVector      = ResetVectorDefault,
  parameter int          RetireCountWidth = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  output logic                        mem_write_enable,
  output logic [31:0]                 mem_write_data,
  input  logic [31:0]                 mem_read_data,
  input  logic                        mem_ready,
  output logic                        halted,
  output logic [RetireCountWidth-1:0] instret
);
  logic [31:0] pc, old_pc, ir, data_reg, a, b, alu_out;
  logic [31:0] rd1, rd2, imm, src_a, src_b, alu_y, pc_next, wd;
  logic        zero, pc_write, ir_write, reg_write, adr_src, ab_write, alu_out_write;
  logic        data_write, retire;
  src_a_t      src_a_sel;
  src_b_t      src_b_sel;
  pc_src_t     pc_src;
  result_t     result_sel;
  imm_src_t    imm_src;
  alu_opcode_t alu_ctrl;

  multi_cycle_control u_ctrl (
    .clk, .rst, .opcode(ir[6:0]), .funct3(ir[14:12]), .funct7b5(ir[30]), .zero, .mem_ready,
    .pc_write, .ir_write, .reg_write, .mem_req, .mem_we(mem_write_enable), .adr_src,
    .ab_write, .alu_out_write, .data_write, .src_a_sel, .src_b_sel, .pc_src, .result_sel,
    .imm_src, .alu_ctrl, .retire, .halted
  );

  register_file u_rf (
    .clk, .we(reg_write), .ra1(ir[19:15]), .ra2(ir[24:20]), .wa(ir[11:7]), .wd, .rd1, .rd2
  );

  imm_extend u_imm (.instr(ir[31:7]), .imm_src, .imm);

  alu u_alu (.a(src_a), .b(src_b), .alu_ctrl, .y(alu_y), .zero);

  always_comb begin
    case (src_a_sel)
      SrcAPc:    src_a = pc;
      SrcAOldPc: src_a = old_pc;
      default:   src_a = a;
    endcase
    case (src_b_sel)
      SrcBReg:  src_b = b;
      SrcBFour: src_b = 32'd4;
      default:  src_b = imm;
    endcase
    case (pc_src)
      PcAlu:   pc_next = alu_y;
      PcOldPc: pc_next = old_pc;
      default: pc_next = alu_out;
    endcase
    case (result_sel)
      ResData: wd = data_reg;
      ResPc:   wd = pc;
      default: wd = alu_out;
    endcase
  end

  assign mem_addr       = adr_src ? alu_out : pc;
  assign mem_write_data = b;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ResetVector; old_pc <= '0; ir <= '0; data_reg <= '0;
      a <= '0; b <= '0; alu_out <= '0; instret <= '0;
    end else begin
      if (ir_write)      begin ir <= mem_read_data; old_pc <= pc; end
      if (pc_write)      pc <= pc_next;
      if (ab_write)      begin a <= rd1; b <= rd2; end
      if (alu_out_write) alu_out <= alu_y;
      if (data_write)    data_reg <= mem_read_data;
      if (retire)        instret <= instret + 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_cycle_datapath.sv
// Bench for multi_cycle_datapath: wait-state memory model with an expected
// transaction scoreboard, retire-count/latency checks, trap and reset cases.
module tb_multi_cycle_datapath;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_write_enable, halted;
  logic [31:0] mem_addr, mem_write_data;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multi_cycle_datapath #(.ResetVector(RV), .RetireCountWidth(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .halted(halted), .instret(instret)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } txn_t;
  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          vectors = 0, miscompares = 0;
  int          wait_cycles = 0, cnt = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] addr);
    return mem.exists(addr) ? mem[addr] : 32'h0;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic push(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    txn_t t;
    t.addr = addr; t.we = we; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Memory model: ready after wait_cycles stalled cycles; scoreboard pops on each completed transfer
  always @(negedge clk) begin
    txn_t e;
    if (mem_req) begin
      if (cnt == 0) begin
        hold_addr = mem_addr; hold_we = mem_write_enable; hold_wdata = mem_write_data;
      end else begin
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_we", mem_write_enable, hold_we);
        if (hold_we) chk("hold_wdata", mem_write_data, hold_wdata);
      end
      if (cnt >= wait_cycles) begin
        mem_ready = 1'b1;
        mem_read_data = mrd(mem_addr);
        chk("txn_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("txn_addr", mem_addr, e.addr);
          chk("txn_we", mem_write_enable, e.we);
          if (e.we) chk("txn_wdata", mem_write_data, e.wdata);
        end
        if (mem_write_enable) mem[mem_addr] = mem_write_data;
        cnt = 0;
      end else begin
        mem_ready = 1'b0; mem_read_data = 32'hDEAD_BEEF; cnt++;
      end
    end else begin
      // a stray ready with no request must be ignored
      mem_ready = 1'b1; mem_read_data = 32'hBAD0_BAD0; cnt = 0;
    end
  end

  task automatic start();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instret", instret, 0);
    #1 rst = 1'b0;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, RV);
  endtask

  task automatic run_until_instret(input int n, input int budget, output int cycles);
    cycles = 0;
    while (instret < n && cycles < budget) begin @(posedge clk); #1; cycles++; end
    chk("instret_reach", instret, n);
  endtask

  task automatic wait_halt(input int budget);
    int c = 0;
    while (!halted && c < budget) begin @(posedge clk); #1; c++; end
    chk("halted", halted, 1);
    chk("q_drained", exp_q.size(), 0);
  endtask

  task automatic load_prog_a();
    mem.delete(); exp_q.delete();
    mem[RV + 0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[RV + 4]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
    mem[RV + 8]  = enc_r(5'd2, 5'd1, 5'd3);
    mem[RV + 12] = enc_s(12'h40, 5'd3, 5'd0);
    mem[RV + 16] = enc_i(12'h40, 5'd0, 3'b010, 5'd4, 7'b0000011);
    mem[RV + 20] = enc_s(12'h44, 5'd4, 5'd0);
    push(RV, 0, 0); push(RV + 4, 0, 0); push(RV + 8, 0, 0); push(RV + 12, 0, 0);
    push(32'h40, 1, 32'd12); push(RV + 16, 0, 0); push(32'h40, 0, 0);
    push(RV + 20, 0, 0); push(32'h44, 1, 32'd12); push(RV + 24, 0, 0);
  endtask

  task automatic load_prog_c();
    mem.delete(); exp_q.delete();
    mem[RV + 0]  = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    mem[RV + 8]  = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    mem[RV + 12] = enc_j(21'd16, 5'd5);
    mem[RV + 28] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
    mem[RV + 32] = enc_s(12'h48, 5'd5, 5'd0);
    mem[RV + 36] = enc_s(12'h4C, 5'd0, 5'd0);
    push(RV, 0, 0); push(RV + 8, 0, 0); push(RV + 12, 0, 0); push(RV + 28, 0, 0);
    push(RV + 32, 0, 0); push(32'h48, 1, RV + 16); push(RV + 36, 0, 0);
    push(32'h4C, 1, 32'd0); push(RV + 40, 0, 0);
  endtask

  task automatic load_prog_d();
    mem.delete(); exp_q.delete();
    mem[RV + 0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[RV + 4] = enc_s(12'h50, 5'd1, 5'd0);
    push(RV, 0, 0); push(RV + 4, 0, 0); push(32'h50, 1, 32'd3); push(RV + 8, 0, 0);
  endtask

  initial begin
    int cyc, seen, found;
    // zero-wait arithmetic/store/load program, then illegal word traps
    wait_cycles = 0; load_prog_a(); start();
    run_until_instret(5, 200, cyc);
    chk("cycles_zero_wait", cyc, 21);
    wait_halt(200);
    chk("instret_at_halt", instret, 6);
    seen = 0;
    repeat (100) begin @(posedge clk); #1; if (mem_req) seen++; end
    chk("trap_no_req", seen, 0);
    chk("trap_halted_sticky", halted, 1);
    chk("trap_instret_frozen", instret, 6);

    // same program with three wait states per access
    wait_cycles = 3; load_prog_a(); start();
    run_until_instret(5, 400, cyc);
    chk("cycles_wait3", cyc, 42);
    wait_halt(400);

    // beq taken, bne not taken, jal link, x0 write discarded
    wait_cycles = 0; load_prog_c(); start();
    wait_halt(200);
    chk("instret_branch_prog", instret, 6);

    // reset while a store waits for ready
    wait_cycles = 3; load_prog_d(); start();
    found = 0; cyc = 0;
    while (!found && cyc < 200) begin
      @(posedge clk); #2; cyc++;
      if (mem_req && mem_write_enable) found = 1;
    end
    chk("store_wait_seen", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_req", mem_req, 0);
    chk("abort_instret", instret, 0);
    chk("abort_no_store", mrd(32'h50), 0);
    load_prog_d(); start();
    wait_halt(400);
    chk("restart_store", mrd(32'h50), 3);
    chk("restart_instret", instret, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_cycle_datapath.md
Name: multi_cycle_datapath

Overview:
RV32I multi-cycle core datapath. It is the successor to the single-cycle datapath.
- A single shared instruction/data memory port with a req/ready handshake, so it tolerates memory wait states.
- A control FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a configurable reset vector, a retired-instruction counter and a sticky halt on illegal opcodes.
- Sits between the top-level core wrapper and the unified memory; reuses register_file, alu and imm_extend.

Parameters:
ResetVector, 32'h0000_0000, PC value loaded on reset.
RetireCountWidth, 32, width of instret counter (legal range 8..64).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
mem_req  output  1  memory transaction request.
mem_addr  output  32  byte address of the current transaction.
mem_write_enable  output  1  1 = store, 0 = load/fetch; valid only while mem_req=1.
mem_write_data  output  32  store data (rs2 value).
mem_read_data  input  32  read data; sampled only in a cycle where mem_req and mem_ready are both 1.
mem_ready  input  1  memory completes the transaction this cycle.
halted  output  1  sticky; core stopped on an illegal instruction.
instret  output  RetireCountWidth  number of retired instructions; wraps modulo 2^RetireCountWidth.

Behaviour:
- Reset: single clock, synchronous active-high reset.
  - pc=ResetVector; state=FETCH; instret=0; halted=0.
  - mem_req=0 in the reset cycle; IR/old_pc/data/A/B/alu_out cleared to 0.
  - Reset asserted mid-transaction drops mem_req from the next edge; any pending ready is ignored.
- Internal registers: pc, old_pc, IR, data_reg, A, B, alu_out. All are written only in the states listed below.
- Handshake:
  - mem_req, mem_addr, mem_write_enable and mem_write_data are held stable until the cycle in which mem_ready=1.
  - The transfer completes in that cycle; mem_ready while mem_req=0 is ignored.
  - There is no timeout.
- FSM states and transitions:
  - FETCH: req=1, addr=pc, we=0. On ready: IR<=rdata, old_pc<=pc, pc<=pc+4, go to DECODE. Otherwise stay.
  - DECODE: A<=rs1, B<=rs2, alu_out<=old_pc+imm (speculative branch/jal target). Next state by opcode:
    - load/store -> MEM_ADR
    - OP -> EXEC_R
    - OP-IMM -> EXEC_I
    - JAL -> JAL
    - BRANCH (funct3 beq/bne only) -> BRANCH
    - anything else -> TRAP
  - MEM_ADR: alu_out<=A+imm. Next: MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: req=1, addr=alu_out. On ready: data_reg<=rdata, go to MEM_WB.
  - MEM_WB: rd<=data_reg, retire, go to FETCH.
  - MEM_WRITE: req=1, we=1, addr=alu_out, wdata=B. On ready: retire, go to FETCH.
  - EXEC_R / EXEC_I: alu_out<=A op B / A op imm, using alu_ctrl decoded from funct3/funct7. Next: ALU_WB.
  - ALU_WB: rd<=alu_out, retire, go to FETCH.
  - JAL: rd<=pc (which equals old_pc+4), pc<=alu_out, retire, go to FETCH.
  - BRANCH: ALU computes A-B. Taken when beq&zero or bne&!zero; if taken pc<=alu_out. Retire; go to FETCH.
  - TRAP: halted=1; mem_req=0 forever; pc holds old_pc of the faulting instruction; exit only via rst.
- Writes to x0 are discarded; x0 always reads 0.
- Latency with zero-wait memory (mem_ready=1 on first req cycle):
  - branch 3 cycles; jal 3; R/I-type 4; sw 4; lw 5.
  - Each wait cycle on the fetch or data access adds 1 cycle.
- instret increments by exactly 1 on each retire transition. No increment in TRAP or in reset.
- All address arithmetic is 32-bit, modulo 2^32. Misaligned addresses are passed through unchecked.

Decomposition:
- rv32i_defs package gains the following; alu_opcode_t and OperandSize are reused.
  - mc_state_t: enum of the 12 states.
  - opcode constants OpLoad, OpStore, OpOp, OpOpImm, OpJal, OpBranch.
  - ResetVector default.
- Sub-module multi_cycle_control holds the FSM plus main/ALU decoders. Outputs:
  - pc_write, ir_write, reg_write, mem_req, mem_we
  - src_a/src_b select, result select, imm_src, alu_ctrl, retire, halted
- The datapath instantiates multi_cycle_control, register_file, alu and imm_extend.

Test Plan:
- Reset with ResetVector=32'h100, zero-wait memory -> first mem_addr=32'h100 with mem_req=1 on the first cycle after rst deasserts; instret=0.
- Program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0x40(x0); lw x4,0x40(x0):
  - store: mem_addr=0x40, mem_write_data=12;
  - x4=12 afterwards;
  - instret=5 after 4+4+4+4+5=21 cycles.
- Same program with mem_ready delayed 3 cycles on every access -> identical results; total cycles 21+3*7=42; address/data stable through every wait.
- beq x1,x1,+8 at 0x0 -> next fetch 0x8; bne x1,x1,+8 -> next fetch 0x4; jal x5,+16 at 0x8 -> x5=0xC, next fetch 0x18.
- Illegal word 32'h0000_0000 fetched at 0x20 -> halted=1, mem_req stays 0 for 100 cycles, instret unchanged; rst clears halted.
- rst asserted while MEM_WRITE waits on mem_ready -> mem_req=0 next cycle, no register/instret change, refetch from ResetVector.
